// File: rtl/sd_spi_sequencer.sv
// SD card SPI-mode sequencer: power-up clocks, CMD0/CMD8/CMD55/ACMD41 init,
// then single-block CMD17 reads streamed one byte at a time, with coded errors.
module sd_spi_sequencer #(
  parameter int PWRUP_BYTES    = 10,
  parameter int RESP_TIMEOUT   = 8,
  parameter int ACMD41_RETRIES = 1000,
  parameter int TOKEN_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_init,
  output logic        init_done,
  input  logic        read_req,
  input  logic [31:0] read_addr,
  output logic        read_busy,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        read_done,
  output logic        error,
  output logic [3:0]  error_code,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  input  logic [7:0]  spi_data_out,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  output logic        ss
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_READY,
    S_CMD17, S_TOKEN, S_DATA, S_CRC, S_ERROR
  } state_t;

  typedef enum logic [1:0] {PH_FRAME, PH_RESP, PH_TAIL} phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [9:0]  data_cnt, data_cnt_n;
  logic [15:0] retry, retry_n, retry_inc;
  logic [31:0] addr, addr_n;
  logic        wait_rx, wait_rx_n;
  logic        spi_start_n, data_valid_n, read_done_n;
  logic        init_done_n, error_n, read_busy_n, ss_n;
  logic [7:0]  spi_data_in_n, data_out_n, tx_byte;
  logic [3:0]  error_code_n, fail_code;
  logic        fail, is_cmd;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [7:0]  cmd_crc;

  assign is_cmd = state inside {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD17};

  // Outgoing byte: command frame bytes while framing, otherwise 0xFF filler.
  always_comb begin
    cmd_idx = 6'd0;
    cmd_arg = 32'd0;
    cmd_crc = 8'h01;
    case (state)
      S_CMD0:   cmd_crc = 8'h95;
      S_CMD8:   begin cmd_idx = 6'd8;  cmd_arg = 32'h0000_01AA; cmd_crc = 8'h87; end
      S_CMD55:  cmd_idx = 6'd55;
      S_ACMD41: begin cmd_idx = 6'd41; cmd_arg = 32'h4000_0000; end
      S_CMD17:  begin cmd_idx = 6'd17; cmd_arg = addr; end
      default:  ;
    endcase
    tx_byte = 8'hFF;
    if (is_cmd && phase == PH_FRAME) begin
      case (cnt[2:0])
        3'd0:    tx_byte = {2'b01, cmd_idx};
        3'd1:    tx_byte = cmd_arg[31:24];
        3'd2:    tx_byte = cmd_arg[23:16];
        3'd3:    tx_byte = cmd_arg[15:8];
        3'd4:    tx_byte = cmd_arg[7:0];
        3'd5:    tx_byte = cmd_crc;
        default: tx_byte = 8'hFF;
      endcase
    end
  end

  always_comb begin
    // NOTE: every variable is given its hold value first, so no path through this block infers a latch.
    state_n       = state;
    phase_n       = phase;
    cnt_n         = cnt;
    data_cnt_n    = data_cnt;
    retry_n       = retry;
    addr_n        = addr;
    wait_rx_n     = wait_rx;
    spi_start_n   = 1'b0;
    spi_data_in_n = spi_data_in;
    data_out_n    = data_out;
    data_valid_n  = 1'b0;
    read_done_n   = 1'b0;
    error_code_n  = error_code;
    fail          = 1'b0;
    fail_code     = 4'd0;
    cnt_inc       = cnt + 16'd1;
    retry_inc     = retry + 16'd1;

    if (start_init && state inside {S_IDLE, S_READY, S_ERROR}) begin
      state_n      = S_PWRUP;
      phase_n      = PH_FRAME;
      cnt_n        = 16'd0;
      retry_n      = 16'd0;
      error_code_n = 4'd0;
    end else if (read_req && state == S_READY) begin
      state_n = S_CMD17;
      phase_n = PH_FRAME;
      cnt_n   = 16'd0;
      addr_n  = read_addr;
    end else if (!(state inside {S_IDLE, S_READY, S_ERROR})) begin
      if (!wait_rx) begin
        if (!spi_busy) begin
          spi_start_n   = 1'b1;
          spi_data_in_n = tx_byte;
          wait_rx_n     = 1'b1;
        end
      end else if (spi_new_data) begin
        wait_rx_n = 1'b0;
        case (state)
          S_PWRUP:
            if (cnt == 16'(PWRUP_BYTES - 1)) begin
              state_n = S_CMD0; phase_n = PH_FRAME; cnt_n = 16'd0;
            end else cnt_n = cnt_inc;
          S_TOKEN:
            if (spi_data_out == 8'hFE) begin
              state_n = S_DATA; data_cnt_n = 10'd0;
            end else if (spi_data_out[7:4] == 4'h0 && spi_data_out != 8'h00) begin
              fail = 1'b1; fail_code = 4'd7;
            end else if (cnt == 16'(TOKEN_TIMEOUT - 1)) begin
              fail = 1'b1; fail_code = 4'd6;
            end else cnt_n = cnt_inc;
          S_DATA: begin
            data_out_n   = spi_data_out;
            data_valid_n = 1'b1;
            if (data_cnt == 10'd511) begin
              state_n = S_CRC; phase_n = PH_RESP; cnt_n = 16'd0;
            end else data_cnt_n = data_cnt + 10'd1;
          end
          S_CRC:
            // Two CRC bytes with ss low, then one trailing filler byte with ss high.
            if (phase == PH_TAIL) begin
              state_n = S_READY; read_done_n = 1'b1;
            end else if (cnt == 16'd1) phase_n = PH_TAIL;
            else cnt_n = cnt_inc;
          default:
            if (phase == PH_FRAME) begin
              if (cnt == 16'd5) begin phase_n = PH_RESP; cnt_n = 16'd0; end
              else cnt_n = cnt_inc;
            end else if (phase == PH_TAIL) begin
              if (cnt == 16'd3) begin
                if (spi_data_out == 8'hAA) begin
                  state_n = S_CMD55; phase_n = PH_FRAME; cnt_n = 16'd0;
                end else begin fail = 1'b1; fail_code = 4'd2; end
              end else cnt_n = cnt_inc;
            end else if (spi_data_out[7]) begin
              if (cnt == 16'(RESP_TIMEOUT - 1)) begin fail = 1'b1; fail_code = 4'd8; end
              else cnt_n = cnt_inc;
            end else begin
              phase_n = PH_FRAME;
              cnt_n   = 16'd0;
              case (state)
                S_CMD0:
                  if (spi_data_out == 8'h01) state_n = S_CMD8;
                  else begin fail = 1'b1; fail_code = 4'd1; end
                S_CMD8:
                  if (spi_data_out == 8'h01) phase_n = PH_TAIL;
                  else begin fail = 1'b1; fail_code = 4'd2; end
                S_CMD55:
                  if (spi_data_out == 8'h00 || spi_data_out == 8'h01) state_n = S_ACMD41;
                  else begin fail = 1'b1; fail_code = 4'd4; end
                S_ACMD41:
                  if (spi_data_out == 8'h00) state_n = S_READY;
                  else if (spi_data_out != 8'h01) begin fail = 1'b1; fail_code = 4'd4; end
                  else if (retry_inc == 16'(ACMD41_RETRIES)) begin fail = 1'b1; fail_code = 4'd3; end
                  else begin retry_n = retry_inc; state_n = S_CMD55; end
                S_CMD17:
                  if (spi_data_out == 8'h00) state_n = S_TOKEN;
                  else begin fail = 1'b1; fail_code = 4'd5; end
                default: ;
              endcase
            end
        endcase
      end
    end

    if (fail) begin
      state_n      = S_ERROR;
      error_code_n = fail_code;
    end

    // Status levels follow the next state, so they change only between byte exchanges.
    init_done_n = (state_n == S_READY);
    error_n     = (state_n == S_ERROR);
    read_busy_n = state_n inside {S_CMD17, S_TOKEN, S_DATA, S_CRC};
    case (state_n)
      S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD17, S_TOKEN, S_DATA: ss_n = 1'b0;
      S_CRC:   ss_n = (phase_n == PH_TAIL);
      default: ss_n = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      phase       <= PH_FRAME;
      cnt         <= 16'd0;
      data_cnt    <= 10'd0;
      retry       <= 16'd0;
      addr        <= 32'd0;
      wait_rx     <= 1'b0;
      spi_start   <= 1'b0;
      spi_data_in <= 8'hFF;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      read_done   <= 1'b0;
      error_code  <= 4'd0;
      init_done   <= 1'b0;
      error       <= 1'b0;
      read_busy   <= 1'b0;
      ss          <= 1'b1;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      cnt         <= cnt_n;
      data_cnt    <= data_cnt_n;
      retry       <= retry_n;
      addr        <= addr_n;
      wait_rx     <= wait_rx_n;
      spi_start   <= spi_start_n;
      spi_data_in <= spi_data_in_n;
      data_out    <= data_out_n;
      data_valid  <= data_valid_n;
      read_done   <= read_done_n;
      error_code  <= error_code_n;
      init_done   <= init_done_n;
      error       <= error_n;
      read_busy   <= read_busy_n;
      ss          <= ss_n;
    end
  end

endmodule

// File: tb/tb_sd_spi_sequencer.sv
// Directed bench for sd_spi_sequencer: byte-level SPIMaster plus SD card model,
// covering init, a block read, response/retry/token failures and async reset.
module tb_sd_spi_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_init, read_req;
  logic [31:0] read_addr;
  logic        init_done, read_busy, data_valid, read_done, error;
  logic [7:0]  data_out;
  logic [3:0]  error_code;
  logic        spi_start;
  logic [7:0]  spi_data_in, spi_data_out;
  logic        spi_busy, spi_new_data;
  logic        ss;

  always #5 clk = ~clk;

  sd_spi_sequencer #(.ACMD41_RETRIES(4)) dut (
    .clk(clk), .rst(rst), .start_init(start_init), .init_done(init_done),
    .read_req(read_req), .read_addr(read_addr), .read_busy(read_busy),
    .data_out(data_out), .data_valid(data_valid), .read_done(read_done),
    .error(error), .error_code(error_code), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .ss(ss)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef enum {M_NORMAL, M_CMD0_SILENT, M_ACMD_STUCK, M_TOKEN_ERR, M_TOKEN_TO} mode_t;
  mode_t mode = M_NORMAL;

  // Card / SPIMaster model state (written only by the model process)
  logic [7:0]  resp_q[$];
  logic [7:0]  rx_next;
  logic [47:0] fbuf, cmd17_frame;
  logic        in_frame, ss_at;
  int fidx, bcnt, acmd_seq;
  int start_count = 0, viol = 0, ss1_bytes = 0, cmd55_cnt = 0, acmd41_cnt = 0, polls = 0;

  task automatic card_cmd();
    case (fbuf[45:40])
      6'd0: begin
        acmd_seq = 0;
        if (mode != M_CMD0_SILENT) begin resp_q.push_back(8'hFF); resp_q.push_back(8'h01); end
      end
      6'd8: begin
        resp_q.push_back(8'h01); resp_q.push_back(8'h00); resp_q.push_back(8'h00);
        resp_q.push_back(8'h01); resp_q.push_back(8'hAA);
      end
      6'd55: begin cmd55_cnt++; resp_q.push_back(8'h01); end
      6'd41: begin
        acmd41_cnt++; acmd_seq++;
        resp_q.push_back((mode == M_ACMD_STUCK || acmd_seq < 3) ? 8'h01 : 8'h00);
      end
      6'd17: begin
        cmd17_frame = fbuf;
        resp_q.push_back(8'h00);
        if (mode == M_NORMAL) begin
          resp_q.push_back(8'hFF); resp_q.push_back(8'hFF); resp_q.push_back(8'hFF);
          resp_q.push_back(8'hFE);
          for (int i = 0; i < 512; i++) resp_q.push_back(8'(i));
          resp_q.push_back(8'h12); resp_q.push_back(8'h34);
        end else if (mode == M_TOKEN_ERR) begin
          resp_q.push_back(8'hFF); resp_q.push_back(8'h05);
        end
      end
      default: ;
    endcase
  endtask

  task automatic card_byte(input logic [7:0] tx, input logic ssv);
    rx_next = 8'hFF;
    if (in_frame) begin
      fbuf = {fbuf[39:0], tx};
      fidx++;
      if (fidx == 6) begin in_frame = 1'b0; polls = 0; card_cmd(); end
    end else if (ssv) begin
      ss1_bytes++;
    end else if (tx[7:6] == 2'b01 && resp_q.size() == 0) begin
      in_frame = 1'b1; fidx = 1; fbuf = {40'd0, tx};
    end else begin
      polls++;
      if (resp_q.size() > 0) rx_next = resp_q.pop_front();
    end
  endtask

  // SPIMaster model: runs on the falling edge, 4-cycle byte exchange.
  initial begin
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00;
    bcnt = 0; in_frame = 1'b0; acmd_seq = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00;
        bcnt = 0; in_frame = 1'b0; resp_q.delete();
      end else begin
        spi_new_data = 1'b0;
        if (spi_start) begin
          start_count++;
          if (spi_busy || bcnt != 0) viol++;
          card_byte(spi_data_in, ss);
          ss_at = ss; bcnt = 4; spi_busy = 1'b1;
        end else if (bcnt > 0) begin
          if (ss !== ss_at) viol++;
          bcnt--;
          if (bcnt == 0) begin spi_busy = 1'b0; spi_new_data = 1'b1; spi_data_out = rx_next; end
        end
      end
    end
  end

  // Output monitor
  int viol2 = 0, dv_count = 0, dv_idx = 0, dv_bad = 0, rd_done_cnt = 0;
  logic prev_start = 1'b0, busy_at_done = 1'b1;
  initial forever begin
    @(negedge clk);
    if (spi_start && prev_start) viol2++;
    prev_start = spi_start;
    if (!read_busy) dv_idx = 0;
    if (data_valid) begin
      if (data_out !== 8'(dv_idx)) dv_bad++;
      dv_idx++; dv_count++;
    end
    if (read_done) begin rd_done_cnt++; busy_at_done = read_busy; end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_init();
    start_init = 1'b1; step(); start_init = 1'b0;
  endtask

  task automatic pulse_read();
    read_req = 1'b1; step(); read_req = 1'b0;
  endtask

  function automatic logic cond(input int which, input int base);
    case (which)
      0:       return init_done;
      1:       return error;
      2:       return rd_done_cnt > base;
      default: return dv_count >= base;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int base, input int budget);
    int n = 0;
    while (!cond(which, base) && n < budget) begin step(); n++; end
    check(tag, 64'(cond(which, base)), 64'd1);
  endtask

  task automatic do_init(input string tag);
    mode = M_NORMAL;
    pulse_init();
    wait_for(tag, 0, 0, 5000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {init_done, read_busy, data_valid, read_done, error, spi_start}, 6'd0);
    check({tag, "_ss"}, ss, 1'b1);
    check({tag, "_spi_data_in"}, spi_data_in, 8'hFF);
    check({tag, "_data_code"}, {data_out, error_code}, 12'd0);
  endtask

  int b0, b1, b2, b3;

  initial begin
    rst = 1'b0; start_init = 1'b0; read_req = 1'b0; read_addr = 32'd0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    step(2);

    // read_req in IDLE is ignored
    b0 = start_count;
    pulse_read();
    step(20);
    check("idle_read_starts", 64'(start_count - b0), 64'd0);
    check("idle_read_busy", read_busy, 1'b0);

    // Normal initialisation
    b0 = ss1_bytes; b1 = cmd55_cnt; b2 = acmd41_cnt;
    do_init("init_done");
    check("init_ss1_bytes", 64'(ss1_bytes - b0), 64'd10);
    check("init_cmd55", 64'(cmd55_cnt - b1), 64'd3);
    check("init_acmd41", 64'(acmd41_cnt - b2), 64'd3);
    check("init_error", error, 1'b0);
    check("init_ss", ss, 1'b1);

    // Block read at 0x800
    b0 = dv_count; b1 = dv_bad; b2 = rd_done_cnt;
    read_addr = 32'h0000_0800;
    pulse_read();
    check("read_busy_set", read_busy, 1'b1);
    wait_for("read_done", 2, b2, 20000);
    step(5);
    check("read_dv_count", 64'(dv_count - b0), 64'd512);
    check("read_dv_bad", 64'(dv_bad - b1), 64'd0);
    check("read_cmd17_frame", cmd17_frame, 48'h51_00_00_08_00_01);
    check("read_done_cnt", 64'(rd_done_cnt - b2), 64'd1);
    check("read_busy_at_done", busy_at_done, 1'b0);
    check("read_ready", {init_done, read_busy}, 2'b10);

    // CMD0 never answered -> response timeout
    mode = M_CMD0_SILENT;
    pulse_init();
    wait_for("cmd0_err", 1, 0, 2000);
    check("cmd0_code", error_code, 4'd8);
    check("cmd0_ss", ss, 1'b1);
    check("cmd0_init_done", init_done, 1'b0);
    check("cmd0_polls", 64'(polls), 64'd8);

    // Restart from ERROR clears error
    mode = M_NORMAL;
    pulse_init();
    check("restart_clear", {error, error_code}, 5'd0);
    wait_for("restart_init", 0, 0, 5000);

    // ACMD41 stuck at idle -> retry exhaustion
    mode = M_ACMD_STUCK;
    b0 = acmd41_cnt;
    pulse_init();
    wait_for("acmd_err", 1, 0, 5000);
    check("acmd_code", error_code, 4'd3);
    check("acmd_count", 64'(acmd41_cnt - b0), 64'd4);

    // Error token during TOKEN
    do_init("tokerr_init");
    mode = M_TOKEN_ERR;
    b0 = dv_count;
    pulse_read();
    wait_for("tokerr_err", 1, 0, 2000);
    check("tokerr_code", error_code, 4'd7);
    check("tokerr_dv", 64'(dv_count - b0), 64'd0);

    // No start token within TOKEN_TIMEOUT polls
    do_init("tokto_init");
    mode = M_TOKEN_TO;
    pulse_read();
    wait_for("tokto_err", 1, 0, 40000);
    check("tokto_code", error_code, 4'd6);
    check("tokto_polls", 64'(polls), 64'd4097);

    // Asynchronous reset in the middle of the data phase
    do_init("rstmid_init");
    b3 = dv_count;
    pulse_read();
    wait_for("rstmid_dv100", 3, b3 + 100, 20000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    step(3);
    rst = 1'b1;
    step(2);

    check("proto_start_while_busy", 64'(viol), 64'd0);
    check("proto_double_start", 64'(viol2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_spi_sequencer.md
Name: sd_spi_sequencer

Overview:
- Controls the byte-wide SPIMaster on behalf of the SD card path.
- Runs the SPI-mode power-up and initialisation sequence: 80 clocks, CMD0, CMD8, then the CMD55/ACMD41 loop.
- Then serves single-block CMD17 reads, streaming 512 data bytes to the audio buffer logic.
- Owns chip-select, checks every R1 response, and reports a coded error instead of hanging.

Parameters:
- PWRUP_BYTES, 10: number of 0xFF bytes sent with ss high before CMD0 (10 bytes = 80 SCK).
- RESP_TIMEOUT, 8: maximum 0xFF poll bytes while waiting for an R1 response.
- ACMD41_RETRIES, 1000: maximum CMD55/ACMD41 iterations before failing.
- TOKEN_TIMEOUT, 4096: maximum poll bytes while waiting for the start-block token.

Ports:
- clk  in  1  system clock; also drives the SPIMaster.
- rst  in  1  asynchronous, active-low reset.
- start_init  in  1  pulse; begins initialisation. Accepted in IDLE, READY or ERROR.
- init_done  out  1  level; card initialised and in READY.
- read_req  in  1  pulse; read one block at read_addr. Accepted only in READY.
- read_addr  in  32  block address, sampled when read_req is accepted.
- read_busy  out  1  high from read acceptance until read_done.
- data_out  out  8  current block data byte.
- data_valid  out  1  one-cycle strobe per data byte.
- read_done  out  1  one-cycle pulse after the block and its CRC have been consumed.
- error  out  1  level; high while in ERROR.
- error_code  out  4  failure cause, held while in ERROR.
- spi_start  out  1  one-cycle request to the SPIMaster for one byte exchange.
- spi_data_in  out  8  byte to transmit.
- spi_data_out  in  8  byte received.
- spi_busy  in  1  SPIMaster transfer in progress.
- spi_new_data  in  1  one-cycle strobe; spi_data_out is valid.
- ss  out  1  card chip-select, active-low.

Behaviour:
- Reset values: init_done, read_busy, data_valid, read_done, error, spi_start = 0. data_out, error_code = 0. spi_data_in = 0xFF. ss = 1. State = IDLE.
- Asserting rst mid-transfer abandons the transfer. SPIMaster shares rst.
- Byte exchange: spi_start is asserted for exactly one cycle, only when spi_busy = 0, with spi_data_in stable. The sequencer then waits for spi_new_data before issuing the next start. Never two starts per byte.
- Command frame is 6 bytes: {2'b01, cmd[5:0]}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc.
  - CMD0: arg 0, crc 0x95.
  - CMD8: arg 0x000001AA, crc 0x87.
  - CMD55: arg 0, crc 0x01.
  - ACMD41: arg 0x40000000, crc 0x01.
  - CMD17: arg = read_addr, crc 0x01.
- After the frame, send 0xFF bytes until the received byte has bit7 = 0 (the R1 response). After RESP_TIMEOUT bytes without a response → ERROR code 8.
- States and transitions:
  - IDLE → PWRUP on start_init.
  - PWRUP: ss = 1, send PWRUP_BYTES × 0xFF.
  - CMD0: ss = 0. R1 must be 0x01, else code 1.
  - CMD8: R1 must be 0x01. Then read 4 tail bytes; the last must be 0xAA, else code 2.
  - CMD55: R1 must be 0x00 or 0x01, else code 4.
  - ACMD41: R1 = 0x00 → READY. R1 = 0x01 → increment retry count and go to CMD55. Count reaching ACMD41_RETRIES → code 3. Any other R1 → code 4.
  - READY: ss = 1, init_done = 1.
  - CMD17: entered on read_req. ss = 0, read_busy = 1. R1 must be 0x00, else code 5.
  - TOKEN: poll 0xFF bytes. 0xFE → DATA. A byte with upper nibble 0000 and nonzero value is an error token → code 7. TOKEN_TIMEOUT polls without a token → code 6.
  - DATA: 512 exchanges of 0xFF. Each received byte is registered to data_out with data_valid = 1 in the cycle after spi_new_data. The byte counter is 10 bits and the state exits when the count reaches 511.
  - CRC: 2 bytes received and discarded. Then one extra 0xFF byte with ss = 1, then READY. read_done pulses in the cycle READY is entered; read_busy drops in the same cycle.
  - ERROR: ss = 1, error = 1, init_done = 0. Exit only via start_init → PWRUP, which clears error and error_code.
- read_req outside READY is ignored, with no latching. start_init during init or read is ignored.
- If read_req and start_init arrive together in READY, start_init wins.
- Every state holds ss constant for the whole duration of a byte exchange.

Test Plan:
- Card model returns 0x01 to CMD0, 0x01 + 00 00 01 AA to CMD8, 0x01 to the first two ACMD41s and 0x00 to the third → exactly 10 bytes sent with ss = 1, three CMD55/ACMD41 pairs, init_done = 1, error = 0.
- read_req with read_addr = 0x00000800; card returns R1 0x00, three 0xFF, then 0xFE, 512 bytes equal to (index mod 256), then 2 CRC bytes → 512 data_valid strobes with matching data_out, CMD17 frame bytes 0x51 00 00 08 00 01, exactly one read_done.
- CMD0 answered only with 0xFF → after 8 poll bytes, error = 1, error_code = 8, ss = 1. A subsequent start_init restarts from PWRUP.
- ACMD41 always returns 0x01, with ACMD41_RETRIES = 4 → error_code = 3 after the 4th ACMD41.
- During TOKEN the card returns 0x05 → error_code = 7, no data_valid. With ACMD41_RETRIES = 4, no token within 4096 polls → error_code = 6.
- rst asserted after 100 data bytes → all outputs at reset values immediately. read_req while in IDLE → ignored, with no spi_start.
